// File: rtl/ai_pkg.sv
// Shared AXI field widths and write-response encodings for the ai_sa blocks.
package ai_pkg;

    localparam int unsigned AI_DATA_WIDTH        = 32;
    localparam int unsigned AI_ADDR_WIDTH        = 32;
    localparam int unsigned AI_TRANS_MST_ID_W    = 5;
    localparam int unsigned AI_TRANS_BURST_W     = 2;
    localparam int unsigned AI_TRANS_DATA_LEN_W  = 3;
    localparam int unsigned AI_TRANS_DATA_SIZE_W = 3;
    localparam int unsigned AI_TRANS_WR_RESP_W   = 2;

    typedef enum logic [1:0] {
        AI_RESP_OKAY   = 2'b00,
        AI_RESP_SLVERR = 2'b10
    } ai_bresp_e;

endpackage

// File: rtl/ai_sa_order_fifo.sv
// W-order FIFO: remembers which master owns each granted AW so write data
// is forwarded in address-grant order. Caller never pushes when full nor
// pops when empty.
module ai_sa_order_fifo
    import ai_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_FULL);

    // Next pointers and occupancy; push+pop together keeps the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ai_sa_write_arbiter.sv
// Multi-master AXI write-channel arbiter in front of one slave.
// AW is arbitrated and registered; W follows grant order through the
// order FIFO; B is routed back by the master index in the upper BID bits.
// Optional macro AI_SA_RR_ARB_EN selects round-robin arbitration instead
// of fixed lowest-index priority.
module ai_sa_write_arbiter
    import ai_pkg::*;
#(
    parameter int unsigned MST_AMT           = 2,
    parameter int unsigned OUTSTANDING_AMT   = 8,
    parameter int unsigned DATA_WIDTH        = AI_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH        = AI_ADDR_WIDTH,
    parameter int unsigned TRANS_MST_ID_W    = AI_TRANS_MST_ID_W,
    parameter int unsigned TRANS_BURST_W     = AI_TRANS_BURST_W,
    parameter int unsigned TRANS_DATA_LEN_W  = AI_TRANS_DATA_LEN_W,
    parameter int unsigned TRANS_DATA_SIZE_W = AI_TRANS_DATA_SIZE_W,
    parameter int unsigned TRANS_WR_RESP_W   = AI_TRANS_WR_RESP_W,
    parameter int unsigned MST_ID_W          = $clog2(MST_AMT)
) (
    input  logic                                   ACLK_i,
    input  logic                                   ARESET_i,
    input  logic [TRANS_MST_ID_W*MST_AMT-1:0]      dsp_AWID_i,
    input  logic [ADDR_WIDTH*MST_AMT-1:0]          dsp_AWADDR_i,
    input  logic [TRANS_BURST_W*MST_AMT-1:0]       dsp_AWBURST_i,
    input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]    dsp_AWLEN_i,
    input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]   dsp_AWSIZE_i,
    input  logic [MST_AMT-1:0]                     dsp_AWVALID_i,
    output logic [MST_AMT-1:0]                     dsp_AWREADY_o,
    input  logic [DATA_WIDTH*MST_AMT-1:0]          dsp_WDATA_i,
    input  logic [MST_AMT-1:0]                     dsp_WLAST_i,
    input  logic [MST_AMT-1:0]                     dsp_WVALID_i,
    output logic [MST_AMT-1:0]                     dsp_WREADY_o,
    output logic [TRANS_MST_ID_W*MST_AMT-1:0]      dsp_BID_o,
    output logic [TRANS_WR_RESP_W*MST_AMT-1:0]     dsp_BRESP_o,
    output logic [MST_AMT-1:0]                     dsp_BVALID_o,
    input  logic [MST_AMT-1:0]                     dsp_BREADY_i,
    output logic [TRANS_MST_ID_W+MST_ID_W-1:0]     s_AWID_o,
    output logic [ADDR_WIDTH-1:0]                  s_AWADDR_o,
    output logic [TRANS_BURST_W-1:0]               s_AWBURST_o,
    output logic [TRANS_DATA_LEN_W-1:0]            s_AWLEN_o,
    output logic [TRANS_DATA_SIZE_W-1:0]           s_AWSIZE_o,
    output logic                                   s_AWVALID_o,
    input  logic                                   s_AWREADY_i,
    output logic [DATA_WIDTH-1:0]                  s_WDATA_o,
    output logic                                   s_WLAST_o,
    output logic                                   s_WVALID_o,
    input  logic                                   s_WREADY_i,
    input  logic [TRANS_MST_ID_W+MST_ID_W-1:0]     s_BID_i,
    input  logic [TRANS_WR_RESP_W-1:0]             s_BRESP_i,
    input  logic                                   s_BVALID_i,
    output logic                                   s_BREADY_o
);

    localparam int unsigned CNT_W = $clog2(OUTSTANDING_AMT + 1);
    localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(OUTSTANDING_AMT);

    logic                         aw_valid_q, aw_valid_d;
    logic [MST_ID_W-1:0]          aw_mst_q,   aw_mst_d;
    logic [TRANS_MST_ID_W-1:0]    aw_id_q,    aw_id_d;
    logic [ADDR_WIDTH-1:0]        aw_addr_q,  aw_addr_d;
    logic [TRANS_BURST_W-1:0]     aw_burst_q, aw_burst_d;
    logic [TRANS_DATA_LEN_W-1:0]  aw_len_q,   aw_len_d;
    logic [TRANS_DATA_SIZE_W-1:0] aw_size_q,  aw_size_d;
    logic [CNT_W-1:0]             out_cnt_q,  out_cnt_d;

    logic                grant_vld;
    logic [MST_ID_W-1:0] grant_idx;
    logic                aw_accept;
    logic                grant;
    logic                fifo_empty;
    logic                fifo_full;
    logic                fifo_pop;
    logic [MST_ID_W-1:0] fifo_head;
    logic [MST_ID_W-1:0] b_idx;
    logic                b_hs;

`ifdef AI_SA_RR_ARB_EN
    logic [MST_ID_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

    // Register slot is free or draining this cycle, and both the order FIFO
    // and the outstanding budget have room; nothing is granted in reset.
    assign aw_accept = (~aw_valid_q | s_AWREADY_i) & ~fifo_full
                     & (out_cnt_q < OUT_MAX) & ~ARESET_i;
    assign grant     = grant_vld & aw_accept;

    // Pick the winning requester.
`ifdef AI_SA_RR_ARB_EN
    always_comb begin : arb_rr
        int unsigned cand;
        cand      = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < MST_AMT; k++) begin
            cand = (32'(rr_ptr_q) + k + 1) % MST_AMT;
            if (!grant_vld && dsp_AWVALID_i[MST_ID_W'(cand)]) begin
                grant_vld = 1'b1;
                grant_idx = MST_ID_W'(cand);
            end
        end
    end
`else
    always_comb begin : arb_fixed
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < MST_AMT; k++) begin
            if (!grant_vld && dsp_AWVALID_i[MST_ID_W'(k)]) begin
                grant_vld = 1'b1;
                grant_idx = MST_ID_W'(k);
            end
        end
    end
`endif

    // One-hot AWREADY for the winner in the grant cycle only.
    always_comb begin
        dsp_AWREADY_o = '0;
        if (grant) dsp_AWREADY_o[grant_idx] = 1'b1;
    end

    // AW register next state: drain on slave ready, reload on a new grant.
    always_comb begin
        aw_valid_d = aw_valid_q;
        aw_mst_d   = aw_mst_q;
        aw_id_d    = aw_id_q;
        aw_addr_d  = aw_addr_q;
        aw_burst_d = aw_burst_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        if (s_AWREADY_i) aw_valid_d = 1'b0;
        if (grant) begin
            aw_valid_d = 1'b1;
            aw_mst_d   = grant_idx;
            for (int unsigned i = 0; i < MST_AMT; i++) begin
                if (grant_idx == MST_ID_W'(i)) begin
                    aw_id_d    = dsp_AWID_i[i*TRANS_MST_ID_W +: TRANS_MST_ID_W];
                    aw_addr_d  = dsp_AWADDR_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                    aw_burst_d = dsp_AWBURST_i[i*TRANS_BURST_W +: TRANS_BURST_W];
                    aw_len_d   = dsp_AWLEN_i[i*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
                    aw_size_d  = dsp_AWSIZE_i[i*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
                end
            end
        end
    end

    // Outstanding counter; decrement is guarded so a stray B never wraps it.
    always_comb begin
        out_cnt_d = out_cnt_q;
        case ({grant, b_hs})
            2'b10:   out_cnt_d = out_cnt_q + 1'b1;
            2'b01:   out_cnt_d = (out_cnt_q != '0) ? out_cnt_q - 1'b1 : out_cnt_q;
            default: out_cnt_d = out_cnt_q;
        endcase
    end

`ifdef AI_SA_RR_ARB_EN
    // Round-robin pointer follows the last winner.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant) rr_ptr_d = grant_idx;
    end

    // Round-robin pointer register.
    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) rr_ptr_q <= '0;
        else          rr_ptr_q <= rr_ptr_d;
    end
`endif

    // AW output register and outstanding counter.
    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            aw_valid_q <= 1'b0;
            aw_mst_q   <= '0;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_burst_q <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            out_cnt_q  <= '0;
        end else begin
            aw_valid_q <= aw_valid_d;
            aw_mst_q   <= aw_mst_d;
            aw_id_q    <= aw_id_d;
            aw_addr_q  <= aw_addr_d;
            aw_burst_q <= aw_burst_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    assign s_AWVALID_o = aw_valid_q;
    assign s_AWID_o    = {aw_mst_q, aw_id_q};
    assign s_AWADDR_o  = aw_addr_q;
    assign s_AWBURST_o = aw_burst_q;
    assign s_AWLEN_o   = aw_len_q;
    assign s_AWSIZE_o  = aw_size_q;

    ai_sa_order_fifo #(
        .WIDTH (MST_ID_W),
        .DEPTH (OUTSTANDING_AMT)
    ) u_order_fifo (
        .clk_i   (ACLK_i),
        .rst_i   (ARESET_i),
        .push_i  (grant),
        .data_i  (grant_idx),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // W path: forward the master at the FIFO head, independent of AW state.
    always_comb begin
        s_WDATA_o    = '0;
        s_WLAST_o    = 1'b0;
        s_WVALID_o   = 1'b0;
        dsp_WREADY_o = '0;
        for (int unsigned i = 0; i < MST_AMT; i++) begin
            if (fifo_head == MST_ID_W'(i)) begin
                s_WDATA_o       = dsp_WDATA_i[i*DATA_WIDTH +: DATA_WIDTH];
                s_WLAST_o       = dsp_WLAST_i[i];
                s_WVALID_o      = dsp_WVALID_i[i] & ~fifo_empty;
                dsp_WREADY_o[i] = s_WREADY_i & ~fifo_empty;
            end
        end
    end

    assign fifo_pop = s_WVALID_o & s_WREADY_i & s_WLAST_o;

    // B path: route by master index; unknown indices are sunk.
    assign b_idx = s_BID_i[TRANS_MST_ID_W +: MST_ID_W];
    assign b_hs  = s_BVALID_i & s_BREADY_o;

    always_comb begin
        dsp_BVALID_o = '0;
        dsp_BID_o    = '0;
        dsp_BRESP_o  = '0;
        s_BREADY_o   = 1'b1;
        for (int unsigned i = 0; i < MST_AMT; i++) begin
            if (b_idx == MST_ID_W'(i)) begin
                dsp_BVALID_o[i] = s_BVALID_i & ~ARESET_i;
                dsp_BID_o[i*TRANS_MST_ID_W +: TRANS_MST_ID_W]    = s_BID_i[TRANS_MST_ID_W-1:0];
                dsp_BRESP_o[i*TRANS_WR_RESP_W +: TRANS_WR_RESP_W] = s_BRESP_i;
                s_BREADY_o      = dsp_BREADY_i[i];
            end
        end
    end

endmodule

// File: tb/tb_ai_sa_write_arbiter.sv
// Self-checking bench for ai_sa_write_arbiter (2-master main instance plus a
// 3-master instance for out-of-range B index handling).
module tb_ai_sa_write_arbiter;
    import ai_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests_run;
    int tests_failed;

    // 2-master DUT
    logic [9:0]  dsp_awid;
    logic [63:0] dsp_awaddr;
    logic [3:0]  dsp_awburst;
    logic [5:0]  dsp_awlen, dsp_awsize;
    logic [1:0]  dsp_awvalid, dsp_awready;
    logic [63:0] dsp_wdata;
    logic [1:0]  dsp_wlast, dsp_wvalid, dsp_wready;
    logic [9:0]  dsp_bid;
    logic [3:0]  dsp_bresp;
    logic [1:0]  dsp_bvalid, dsp_bready;
    logic [5:0]  s_awid;
    logic [31:0] s_awaddr;
    logic [1:0]  s_awburst;
    logic [2:0]  s_awlen, s_awsize;
    logic        s_awvalid, s_awready;
    logic [31:0] s_wdata;
    logic        s_wlast, s_wvalid, s_wready;
    logic [5:0]  s_bid;
    logic [1:0]  s_bresp;
    logic        s_bvalid, s_bready;

    // 3-master DUT
    logic [14:0] t_awid;
    logic [95:0] t_awaddr;
    logic [5:0]  t_awburst;
    logic [8:0]  t_awlen, t_awsize;
    logic [2:0]  t_awvalid, t_awready;
    logic [95:0] t_wdata;
    logic [2:0]  t_wlast, t_wvalid, t_wready;
    logic [14:0] t_bid;
    logic [5:0]  t_bresp;
    logic [2:0]  t_bvalid, t_bready;
    logic [6:0]  t_s_awid;
    logic [31:0] t_s_awaddr;
    logic [1:0]  t_s_awburst;
    logic [2:0]  t_s_awlen, t_s_awsize;
    logic        t_s_awvalid, t_s_awready;
    logic [31:0] t_s_wdata;
    logic        t_s_wlast, t_s_wvalid, t_s_wready;
    logic [6:0]  t_s_bid;
    logic [1:0]  t_s_bresp;
    logic        t_s_bvalid, t_s_bready;

    typedef struct {
        logic [5:0]  id;
        logic [31:0] addr;
        logic [2:0]  len;
    } aw_exp_t;

    aw_exp_t     aw_q[$];
    logic [31:0] w_q[$];
    int unsigned ord_q[$];
    int unsigned rr_ptr;

    ai_sa_write_arbiter #(.MST_AMT(2), .OUTSTANDING_AMT(8)) dut (
        .ACLK_i(clk), .ARESET_i(rst),
        .dsp_AWID_i(dsp_awid), .dsp_AWADDR_i(dsp_awaddr), .dsp_AWBURST_i(dsp_awburst),
        .dsp_AWLEN_i(dsp_awlen), .dsp_AWSIZE_i(dsp_awsize),
        .dsp_AWVALID_i(dsp_awvalid), .dsp_AWREADY_o(dsp_awready),
        .dsp_WDATA_i(dsp_wdata), .dsp_WLAST_i(dsp_wlast), .dsp_WVALID_i(dsp_wvalid),
        .dsp_WREADY_o(dsp_wready),
        .dsp_BID_o(dsp_bid), .dsp_BRESP_o(dsp_bresp), .dsp_BVALID_o(dsp_bvalid),
        .dsp_BREADY_i(dsp_bready),
        .s_AWID_o(s_awid), .s_AWADDR_o(s_awaddr), .s_AWBURST_o(s_awburst),
        .s_AWLEN_o(s_awlen), .s_AWSIZE_o(s_awsize), .s_AWVALID_o(s_awvalid),
        .s_AWREADY_i(s_awready),
        .s_WDATA_o(s_wdata), .s_WLAST_o(s_wlast), .s_WVALID_o(s_wvalid), .s_WREADY_i(s_wready),
        .s_BID_i(s_bid), .s_BRESP_i(s_bresp), .s_BVALID_i(s_bvalid), .s_BREADY_o(s_bready)
    );

    ai_sa_write_arbiter #(.MST_AMT(3), .OUTSTANDING_AMT(8)) dut3 (
        .ACLK_i(clk), .ARESET_i(rst),
        .dsp_AWID_i(t_awid), .dsp_AWADDR_i(t_awaddr), .dsp_AWBURST_i(t_awburst),
        .dsp_AWLEN_i(t_awlen), .dsp_AWSIZE_i(t_awsize),
        .dsp_AWVALID_i(t_awvalid), .dsp_AWREADY_o(t_awready),
        .dsp_WDATA_i(t_wdata), .dsp_WLAST_i(t_wlast), .dsp_WVALID_i(t_wvalid),
        .dsp_WREADY_o(t_wready),
        .dsp_BID_o(t_bid), .dsp_BRESP_o(t_bresp), .dsp_BVALID_o(t_bvalid),
        .dsp_BREADY_i(t_bready),
        .s_AWID_o(t_s_awid), .s_AWADDR_o(t_s_awaddr), .s_AWBURST_o(t_s_awburst),
        .s_AWLEN_o(t_s_awlen), .s_AWSIZE_o(t_s_awsize), .s_AWVALID_o(t_s_awvalid),
        .s_AWREADY_i(t_s_awready),
        .s_WDATA_o(t_s_wdata), .s_WLAST_o(t_s_wlast), .s_WVALID_o(t_s_wvalid),
        .s_WREADY_i(t_s_wready),
        .s_BID_i(t_s_bid), .s_BRESP_i(t_s_bresp), .s_BVALID_i(t_s_bvalid), .s_BREADY_o(t_s_bready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dsp_awid = '0; dsp_awaddr = '0; dsp_awburst = '0; dsp_awlen = '0; dsp_awsize = '0;
        dsp_awvalid = '0; dsp_wdata = '0; dsp_wlast = '0; dsp_wvalid = '0; dsp_bready = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bid = '0; s_bresp = '0; s_bvalid = 1'b0;
        t_awid = '0; t_awaddr = '0; t_awburst = '0; t_awlen = '0; t_awsize = '0;
        t_awvalid = '0; t_wdata = '0; t_wlast = '0; t_wvalid = '0; t_bready = '0;
        t_s_awready = 1'b0; t_s_wready = 1'b0; t_s_bid = '0; t_s_bresp = '0; t_s_bvalid = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        aw_q.delete();
        w_q.delete();
        ord_q.delete();
        rr_ptr = 0;
        #1;
    endtask

    task automatic set_aw(input int unsigned m, input logic [4:0] id,
                          input logic [31:0] addr, input logic [2:0] len);
        dsp_awid[m*5 +: 5]    = id;
        dsp_awaddr[m*32 +: 32] = addr;
        dsp_awburst[m*2 +: 2] = 2'b01;
        dsp_awlen[m*3 +: 3]   = len;
        dsp_awsize[m*3 +: 3]  = 3'd2;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        dsp_awvalid = 2'b11; dsp_wvalid = 2'b11; dsp_wlast = 2'b11;
        s_awready = 1'b1; s_wready = 1'b1;
        #2;
        tests_run++;
        if (dsp_awready !== 2'b00 || s_awvalid !== 1'b0 || s_wvalid !== 1'b0 || dsp_wready !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_outputs: awready=%b s_awvalid=%b s_wvalid=%b wready=%b, required 00 0 0 00",
                     dsp_awready, s_awvalid, s_wvalid, dsp_wready);
        end
        tick();
        tests_run++;
        if (s_awvalid !== 1'b0 || dsp_awready !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_held_edge: s_awvalid=%b awready=%b, required 0 00", s_awvalid, dsp_awready);
        end
        apply_reset();
    endtask

    task automatic test_single();
        aw_exp_t e;
        logic [31:0] d;
        apply_reset();
        set_aw(0, 5'd3, 32'h0000_1000, 3'd3);
        dsp_awvalid = 2'b01; s_awready = 1'b1;
        #1;
        tests_run++;
        if (dsp_awready !== 2'b01 || s_awvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_grant: awready=%b s_awvalid=%b, required 01 0", dsp_awready, s_awvalid);
        end
        e.id = {1'b0, 5'd3}; e.addr = 32'h0000_1000; e.len = 3'd3;
        aw_q.push_back(e);
        tick();
        dsp_awvalid = 2'b00;
        #1;
        e = aw_q.pop_front();
        tests_run++;
        if (s_awvalid !== 1'b1 || s_awid !== e.id || s_awaddr !== e.addr || s_awlen !== e.len) begin
            tests_failed++;
            $display("FAIL single_aw_out: valid=%b id=%h addr=%h len=%0d, required 1 %h %h %0d",
                     s_awvalid, s_awid, s_awaddr, s_awlen, e.id, e.addr, e.len);
        end
        s_wready = 1'b1;
        for (int unsigned b = 0; b < 4; b++) begin
            d = 32'hD000_0000 + b;
            dsp_wdata[31:0] = d; dsp_wlast[0] = (b == 3); dsp_wvalid[0] = 1'b1;
            w_q.push_back(d);
            #1;
            tests_run++;
            if (s_wvalid !== 1'b1 || dsp_wready !== 2'b01 || s_wdata !== w_q[0] || s_wlast !== (b == 3)) begin
                tests_failed++;
                $display("FAIL single_w_beat%0d: wvalid=%b wready=%b data=%h last=%b, required 1 01 %h %b",
                         b, s_wvalid, dsp_wready, s_wdata, s_wlast, w_q[0], (b == 3));
            end
            if (s_wvalid && s_wready) d = w_q.pop_front();
            tick();
        end
        #1;
        tests_run++;
        if (s_wvalid !== 1'b0 || dsp_wready !== 2'b00) begin
            tests_failed++;
            $display("FAIL single_fifo_pop: s_wvalid=%b wready=%b, required 0 00", s_wvalid, dsp_wready);
        end
        dsp_wvalid = 2'b00;
        s_bid = {1'b0, 5'd3}; s_bresp = AI_RESP_OKAY; s_bvalid = 1'b1; dsp_bready = 2'b01;
        #1;
        tests_run++;
        if (dsp_bvalid !== 2'b01 || dsp_bid[4:0] !== 5'd3 || s_bready !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_b: bvalid=%b bid=%h s_bready=%b, required 01 03 1", dsp_bvalid, dsp_bid[4:0], s_bready);
        end
        tick();
        s_bvalid = 1'b0;
    endtask

    task automatic test_arbitration();
        aw_exp_t e;
        int unsigned exp_m;
        int unsigned head;
        logic [31:0] exp_d;
        apply_reset();
        set_aw(0, 5'd7, 32'h0000_0100, 3'd0);
        set_aw(1, 5'd9, 32'h0000_0200, 3'd0);
        dsp_awvalid = 2'b11; s_awready = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            if (aw_q.size() != 0) begin
                e = aw_q.pop_front();
                tests_run++;
                if (s_awvalid !== 1'b1 || s_awid !== e.id || s_awaddr !== e.addr) begin
                    tests_failed++;
                    $display("FAIL arb_aw_out%0d: valid=%b id=%h addr=%h, required 1 %h %h",
                             c, s_awvalid, s_awid, s_awaddr, e.id, e.addr);
                end
            end
`ifdef AI_SA_RR_ARB_EN
            exp_m = (rr_ptr + 1) % 2;
            rr_ptr = exp_m;
`else
            exp_m = 0;
`endif
            tests_run++;
            if (dsp_awready !== (2'b01 << exp_m)) begin
                tests_failed++;
                $display("FAIL arb_grant%0d: awready=%b, required %b", c, dsp_awready, 2'b01 << exp_m);
            end
            e.id   = {exp_m[0], (exp_m == 0) ? 5'd7 : 5'd9};
            e.addr = (exp_m == 0) ? 32'h0000_0100 : 32'h0000_0200;
            e.len  = 3'd0;
            aw_q.push_back(e);
            ord_q.push_back(exp_m);
            tick();
        end
        dsp_awvalid = 2'b00;
        #1;
        e = aw_q.pop_front();
        tests_run++;
        if (s_awvalid !== 1'b1 || s_awid !== e.id) begin
            tests_failed++;
            $display("FAIL arb_aw_last: valid=%b id=%h, required 1 %h", s_awvalid, s_awid, e.id);
        end
        tick();
        dsp_wdata = {32'hB000_0001, 32'hA000_0000};
        dsp_wlast = 2'b11; dsp_wvalid = 2'b11; s_wready = 1'b1;
        #1;
        tests_run++;
        if (s_awvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL arb_aw_drained: s_awvalid=%b, required 0", s_awvalid);
        end
        while (ord_q.size() != 0) begin
            head  = ord_q.pop_front();
            exp_d = (head == 0) ? 32'hA000_0000 : 32'hB000_0001;
            tests_run++;
            if (s_wvalid !== 1'b1 || s_wdata !== exp_d || dsp_wready !== (2'b01 << head)) begin
                tests_failed++;
                $display("FAIL arb_w_order: wvalid=%b data=%h wready=%b, required 1 %h %b",
                         s_wvalid, s_wdata, dsp_wready, exp_d, 2'b01 << head);
            end
            tick();
        end
        tests_run++;
        if (s_wvalid !== 1'b0 || dsp_wready !== 2'b00) begin
            tests_failed++;
            $display("FAIL arb_w_empty: wvalid=%b wready=%b, required 0 00", s_wvalid, dsp_wready);
        end
    endtask

    task automatic test_b_routing();
        apply_reset();
        s_bid = {1'b1, 5'd5}; s_bresp = AI_RESP_SLVERR; s_bvalid = 1'b1; dsp_bready = 2'b00;
        #1;
        tests_run++;
        if (dsp_bvalid !== 2'b10 || dsp_bid[9:5] !== 5'd5 || dsp_bresp[3:2] !== 2'b10 || s_bready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b_route: bvalid=%b bid=%h bresp=%b s_bready=%b, required 10 05 10 0",
                     dsp_bvalid, dsp_bid[9:5], dsp_bresp[3:2], s_bready);
        end
        tick();
        tests_run++;
        if (dsp_bvalid !== 2'b10 || s_bready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b_hold: bvalid=%b s_bready=%b, required 10 0", dsp_bvalid, s_bready);
        end
        dsp_bready = 2'b10;
        #1;
        tests_run++;
        if (s_bready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b_ready_raise: s_bready=%b, required 1", s_bready);
        end
        tick();
        s_bvalid = 1'b0; dsp_bready = 2'b00;
        #1;
        tests_run++;
        if (dsp_bvalid !== 2'b00) begin
            tests_failed++;
            $display("FAIL b_done: bvalid=%b, required 00", dsp_bvalid);
        end
    endtask

    // Runs right after test_b_routing: the counter saw a B at zero first.
    task automatic test_outstanding();
        set_aw(0, 5'd2, 32'h0000_0300, 3'd0);
        dsp_awvalid = 2'b01; s_awready = 1'b1;
        dsp_wvalid = 2'b01; dsp_wlast = 2'b01; s_wready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (dsp_awready !== 2'b01) begin
                tests_failed++;
                $display("FAIL outst_grant%0d: awready=%b, required 01", k, dsp_awready);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (dsp_awready !== 2'b00) begin
                tests_failed++;
                $display("FAIL outst_block%0d: awready=%b, required 00", k, dsp_awready);
            end
            tick();
        end
        s_bid = {1'b0, 5'd2}; s_bvalid = 1'b1; dsp_bready = 2'b01;
        #1;
        tests_run++;
        if (dsp_awready !== 2'b00 || s_bready !== 1'b1) begin
            tests_failed++;
            $display("FAIL outst_b_cycle: awready=%b s_bready=%b, required 00 1", dsp_awready, s_bready);
        end
        tick();
        s_bvalid = 1'b0;
        #1;
        tests_run++;
        if (dsp_awready !== 2'b01) begin
            tests_failed++;
            $display("FAIL outst_ninth: awready=%b, required 01", dsp_awready);
        end
        tick();
        tests_run++;
        if (dsp_awready !== 2'b00) begin
            tests_failed++;
            $display("FAIL outst_full_again: awready=%b, required 00", dsp_awready);
        end
    endtask

    task automatic test_sink();
        t_s_bid = {2'd3, 5'd1}; t_s_bvalid = 1'b1; t_bready = 3'b000;
        #1;
        tests_run++;
        if (t_s_bready !== 1'b1 || t_bvalid !== 3'b000) begin
            tests_failed++;
            $display("FAIL sink_idx3: s_bready=%b bvalid=%b, required 1 000", t_s_bready, t_bvalid);
        end
        t_s_bid = {2'd2, 5'd6};
        #1;
        tests_run++;
        if (t_bvalid !== 3'b100 || t_s_bready !== 1'b0 || t_bid[14:10] !== 5'd6) begin
            tests_failed++;
            $display("FAIL sink_idx2: bvalid=%b s_bready=%b bid=%h, required 100 0 06",
                     t_bvalid, t_s_bready, t_bid[14:10]);
        end
        t_s_bvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_aw(1, 5'd4, 32'h0000_0040, 3'd1);
        dsp_awvalid = 2'b10; s_awready = 1'b0;
        #1;
        tests_run++;
        if (dsp_awready !== 2'b10) begin
            tests_failed++;
            $display("FAIL mid_grant: awready=%b, required 10", dsp_awready);
        end
        tick();
        tests_run++;
        if (dsp_awready !== 2'b00 || s_awvalid !== 1'b1 || s_awid !== {1'b1, 5'd4}) begin
            tests_failed++;
            $display("FAIL mid_stall: awready=%b valid=%b id=%h, required 00 1 24", dsp_awready, s_awvalid, s_awid);
        end
        tick();
        dsp_wdata[63:32] = 32'h5555_AAAA; dsp_wvalid = 2'b10; dsp_wlast = 2'b00; s_wready = 1'b1;
        s_bid = {1'b0, 5'd1}; s_bvalid = 1'b1;
        #1;
        tests_run++;
        if (s_awvalid !== 1'b1 || s_awaddr !== 32'h0000_0040 || s_wvalid !== 1'b1
            || s_wdata !== 32'h5555_AAAA || dsp_bvalid !== 2'b01) begin
            tests_failed++;
            $display("FAIL mid_pre: awvalid=%b addr=%h wvalid=%b wdata=%h bvalid=%b, required 1 00000040 1 5555aaaa 01",
                     s_awvalid, s_awaddr, s_wvalid, s_wdata, dsp_bvalid);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (s_awvalid !== 1'b0 || s_wvalid !== 1'b0 || dsp_bvalid !== 2'b00 || dsp_awready !== 2'b00) begin
            tests_failed++;
            $display("FAIL mid_reset: awvalid=%b wvalid=%b bvalid=%b awready=%b, required 0 0 00 00",
                     s_awvalid, s_wvalid, dsp_bvalid, dsp_awready);
        end
        dsp_awvalid = 2'b00; s_bvalid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        tick();
        tests_run++;
        if (s_awvalid !== 1'b0 || s_wvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_no_replay: awvalid=%b wvalid=%b, required 0 0", s_awvalid, s_wvalid);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rr_ptr = 0;
        test_reset();
        test_single();
        test_arbitration();
        test_b_routing();
        test_outstanding();
        test_sink();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
